shift_reg_gated_stall: RTL and testbench
========================================

# shift_reg_gated_stall

Stallable, clock-gate-friendly shift register for arbitrary depth and payload type with valid/ready handshakes on both sides. It replaces the plain gated shift register wherever the consumer can apply backpressure. Optional bubble collapsing, a synchronous flush and an occupancy count are included. Its data registers load only on accepted beats, so synthesis can infer one ICG per stage.

## Interface
- `Depth`, default 4: number of register stages; 0 means combinational pass-through.
- `dtype`, default `logic`: payload type.
- `BubbleCollapse`, default 1'b1:
  - 1: each stage advances independently, so empty stages fill while downstream is stalled.
  - 0: the whole chain advances only when `ready_i` is high (lock-step).
- `CntWidth`, localparam = max(1, $clog2(Depth+1)): width of `count_o`.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  synchronous flush; invalidates all stages.
- `valid_i`  in  1  upstream beat valid.
- `ready_o`  out  1  upstream beat accepted when `valid_i && ready_o`.
- `data_i`  in  dtype  upstream payload.
- `valid_o`  out  1  downstream beat valid; equals `valid_q[Depth-1]`.
- `ready_i`  in  1  downstream ready.
- `data_o`  out  dtype  downstream payload; equals `data_q[Depth-1]`.
- `count_o`  out  CntWidth  number of valid stages (popcount of `valid_q`).

## Operation
**Per-stage state**
- Stage i holds `valid_q[i]` and `data_q[i]`.
- Input to stage 0 is `valid_i`/`data_i`; input to stage i>0 is stage i-1.

**Stage enable `en[i]`**
- Define `en[Depth] = ready_i`.
- BubbleCollapse=1: `en[i] = !valid_q[i] || en[i+1]`.
- BubbleCollapse=0: `en[i] = ready_i` for every i.
- `ready_o = en[0] && !flush_i`.

**Register updates**
- Valid flag: when `en[i]`, `valid_q[i] <= valid_d[i]`; otherwise it holds. The valid flag is never gated by data.
- Data: `data_q[i] <= data_d[i]` only when `en[i] && valid_d[i]`. This is the gating condition. Data is never rewritten with bubbles, and a stage's data is stable while it is stalled.

**Flush**
- When `flush_i` is high, every `valid_q` goes to 0 next cycle, with priority over all shifting.
- Data registers are not loaded during flush.
- The upstream beat is not accepted, since `ready_o` is 0.
- A beat presented on `valid_o` during the flush cycle counts as delivered if `ready_i` is 1.

**Depth==0**
- `valid_o = valid_i`, `data_o = data_i`, `ready_o = ready_i && !flush_i`, `count_o = 0`.
- The flush only masks the handshake.

**Ordering and loss**
- Beats are never dropped except by flush, never duplicated, and never reordered.
- `count_o` is combinational from `valid_q`.

## Timing
- **Reset:** all `valid_q` = 0 and all `data_q` = '0. So `valid_o` = 0, `data_o` = '0 and `count_o` = 0. After reset `ready_o` = 1, provided `flush_i` = 0 and, in the lock-step case, `ready_i` = 1.
- **Latency:** a beat accepted at edge t appears on `valid_o` after edge t+Depth-1. That means Depth cycles when there are no stalls, and one extra cycle per stalled cycle seen at the output.
- **Throughput:** 1 beat/cycle with `ready_i` held high.
- **Full:** BubbleCollapse=1 with all stages valid and `ready_i` = 0 gives `ready_o` = 0.
- **Combinational paths:**
  - `ready_i` to `ready_o` is a combinational chain of Depth AND/OR levels; this is a documented long path.
  - `valid_o`/`data_o` are registered outputs.
- **Simultaneous events:**
  - Accepting in and emitting out in the same cycle on a full chain is allowed (pass-through of ready), and `count_o` is unchanged.
  - Flush together with `valid_i` leaves the chain empty next cycle.
- **Reset mid-operation:** the asynchronous reset clears all state immediately; in-flight beats are lost.

## Structure
- No shared package is needed. `CntWidth` is local and `dtype` is a parameter.
- Use the team `FF` macro for the valid flags and the `FFL` macro for data with load = `en[i] && valid_d[i]`. Both reset to '0.
- The natural sub-module is `shift_reg_gated_stage`, one stage with ports `en_i`, `flush_i`, `valid_i`, `data_i`, `valid_o`, `data_o`. The top level generates Depth instances plus the enable chain and the popcount.

## Test plan
- **Streaming:** Depth=4, `ready_i`=1, input 0x1..0x8 on consecutive cycles. Require `valid_o` at cycle 4 with `data_o`=0x1, then 0x2..0x8 back-to-back, and `count_o` steady at 4.
- **Bubble collapse:** Depth=4, BubbleCollapse=1, inject 0xA, 2 idle cycles, then 0xB. Hold `ready_i`=0 for 6 cycles. Require the chain to hold {0xB, 0xA} packed at the output end, `count_o`=2 and `ready_o`=1. With `ready_i`=1, 0xA then 0xB come out on consecutive cycles.
- **Lock-step:** same stimulus with BubbleCollapse=0. Require `ready_o`=0 whenever `ready_i`=0 and the gap between 0xA and 0xB preserved at the output.
- **Full and gating:** fill 4 stages (0x11..0x14) with `ready_i`=0. Require `ready_o`=0, `count_o`=4, and `data_q` unchanged while `valid_i` toggles with new data 0xFF.
- **Flush:** flush on a full chain with `valid_i`=1 and `data_i`=0x55. Require the next cycle `count_o`=0 and `valid_o`=0, and that 0x55 never appears.
- **Reset and Depth=0:** assert `rst_ni` low mid-stream and require immediate `valid_o`=0, `data_o`='0, `count_o`=0. With Depth=0, require `data_o`=`data_i` in the same cycle and `ready_o`=`ready_i`.

Source files
------------

// File: rtl/shift_reg_gated_stall_pkg.sv
// Shared helpers for the stallable gated shift register.
package shift_reg_gated_stall_pkg;

    // Width of the occupancy counter: must hold 0..depth, and never shrinks below one bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/shift_reg_gated_stall_stage.sv
// One stage of the stallable shift register: a valid flag that follows the enable,
// and a payload register that loads only on real beats so it maps onto a single ICG.
module shift_reg_gated_stall_stage
    import shift_reg_gated_stall_pkg::*;
#(
    parameter type dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic flush_i,
    input  logic valid_i,
    input  dtype data_i,
    output logic valid_o,
    output dtype data_o
);

    logic load;

    // Bubbles and flushes never touch the payload, keeping it stable while stalled.
    assign load = en_i && valid_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
        end else if (en_i) begin
            valid_o <= valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o <= '0;
        end else if (load) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/shift_reg_gated_stall.sv
// Stallable, clock-gate-friendly shift register with valid/ready on both sides,
// optional bubble collapsing, synchronous flush and an occupancy count.
module shift_reg_gated_stall
    import shift_reg_gated_stall_pkg::*;
#(
    parameter int unsigned Depth          = 4,
    parameter type         dtype          = logic,
    parameter bit          BubbleCollapse = 1'b1,
    localparam int unsigned CntWidth      = cnt_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  dtype                data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output dtype                data_o,
    output logic [CntWidth-1:0] count_o
);

    if (Depth == 0) begin : gen_bypass
        // No storage: flush can only mask the upstream handshake.
        assign valid_o = valid_i;
        assign data_o  = data_i;
        assign ready_o = ready_i && !flush_i;
        assign count_o = '0;
    end else begin : gen_pipe
        logic [Depth:0]   en;
        logic [Depth-1:0] valid_q;
        logic [Depth-1:0] valid_d;
        dtype             data_q [Depth];
        dtype             data_d [Depth];
        logic [CntWidth-1:0] cnt;

        // Ready ripples back from the output; with collapsing an empty stage is
        // always willing to take a beat. This is a Depth-level combinational path.
        always_comb begin
            en        = '0;
            en[Depth] = ready_i;
            for (int i = int'(Depth) - 1; i >= 0; i--) begin
                en[i] = BubbleCollapse ? (!valid_q[i] || en[i+1]) : ready_i;
            end
        end

        for (genvar i = 0; i < Depth; i++) begin : gen_stage
            if (i == 0) begin : gen_head
                assign valid_d[i] = valid_i;
                assign data_d[i]  = data_i;
            end else begin : gen_link
                assign valid_d[i] = valid_q[i-1];
                assign data_d[i]  = data_q[i-1];
            end

            shift_reg_gated_stall_stage #(
                .dtype (dtype)
            ) u_stage (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .en_i    (en[i]),
                .flush_i (flush_i),
                .valid_i (valid_d[i]),
                .data_i  (data_d[i]),
                .valid_o (valid_q[i]),
                .data_o  (data_q[i])
            );
        end

        always_comb begin
            cnt = '0;
            for (int i = 0; i < int'(Depth); i++) begin
                cnt = cnt + CntWidth'(valid_q[i]);
            end
        end

        assign ready_o = en[0] && !flush_i;
        assign valid_o = valid_q[Depth-1];
        assign data_o  = data_q[Depth-1];
        assign count_o = cnt;
    end

endmodule

// File: tb/tb_shift_reg_gated_stall.sv
// Bench for shift_reg_gated_stall: collapsing, lock-step and pass-through instances
// driven in parallel and compared against a slot/queue model of the handshake rules.
module tb_shift_reg_gated_stall;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       vin   = 1'b0;
    logic       rdy   = 1'b1;
    logic [7:0] din   = '0;

    logic       b_ready, b_valid, l_ready, l_valid, p_ready, p_valid;
    logic [7:0] b_data, l_data, p_data;
    logic [2:0] b_cnt, l_cnt;
    logic       p_cnt;

    shift_reg_gated_stall #(.Depth(4), .dtype(logic [7:0]), .BubbleCollapse(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(b_ready),
        .data_i(din), .valid_o(b_valid), .ready_i(rdy), .data_o(b_data), .count_o(b_cnt));

    shift_reg_gated_stall #(.Depth(4), .dtype(logic [7:0]), .BubbleCollapse(1'b0)) dut_l (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(l_ready),
        .data_i(din), .valid_o(l_valid), .ready_i(rdy), .data_o(l_data), .count_o(l_cnt));

    shift_reg_gated_stall #(.Depth(0), .dtype(logic [7:0]), .BubbleCollapse(1'b1)) dut_p (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(vin), .ready_o(p_ready),
        .data_i(din), .valid_o(p_valid), .ready_i(rdy), .data_o(p_data), .count_o(p_cnt));

    int total = 0;
    int bad   = 0;

    // Model: four slots per chain (slot 3 is the output), plus in-order queues of accepted beats.
    bit   [3:0] mv_b, mv_l;
    logic [7:0] md_b [4];
    logic [7:0] md_l [4];
    logic [7:0] q_b [$];
    logic [7:0] q_l [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv_b = '0;
        mv_l = '0;
        for (int p = 0; p < 4; p++) begin
            md_b[p] = '0;
            md_l[p] = '0;
        end
        q_b.delete();
        q_l.delete();
    endtask

    task automatic check_all();
        chk("bc_valid", 32'(b_valid), 32'(mv_b[3]));
        chk("bc_data",  32'(b_data),  32'(md_b[3]));
        chk("bc_count", 32'(b_cnt),   $countones(mv_b));
        chk("bc_ready", 32'(b_ready), 32'((rdy || mv_b != 4'hF) && !flush));
        chk("ls_valid", 32'(l_valid), 32'(mv_l[3]));
        chk("ls_data",  32'(l_data),  32'(md_l[3]));
        chk("ls_count", 32'(l_cnt),   $countones(mv_l));
        chk("ls_ready", 32'(l_ready), 32'(rdy && !flush));
        chk("pt_valid", 32'(p_valid), 32'(vin));
        chk("pt_data",  32'(p_data),  32'(din));
        chk("pt_ready", 32'(p_ready), 32'(rdy && !flush));
        chk("pt_count", 32'(p_cnt),   32'(0));
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_update();
        bit acc_b, acc_l;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc_b = vin && (rdy || mv_b != 4'hF) && !flush;
        acc_l = vin && rdy && !flush;
        if (mv_b[3] && rdy) begin
            if (q_b.size() > 0) chk("bc_order", 32'(b_data), 32'(q_b.pop_front()));
            else                chk("bc_extra", 32'(b_valid), 32'(0));
        end
        if (mv_l[3] && rdy) begin
            if (q_l.size() > 0) chk("ls_order", 32'(l_data), 32'(q_l.pop_front()));
            else                chk("ls_extra", 32'(l_valid), 32'(0));
        end
        if (flush) begin
            mv_b = '0;
            mv_l = '0;
            q_b.delete();
            q_l.delete();
            return;
        end
        if (acc_b) q_b.push_back(din);
        if (acc_l) q_l.push_back(din);
        // Collapsing: output slot drains, then every beat slides into a hole right ahead of it.
        if (rdy) mv_b[3] = 1'b0;
        for (int p = 2; p >= 0; p--) begin
            if (mv_b[p] && !mv_b[p+1]) begin
                mv_b[p+1] = 1'b1;
                md_b[p+1] = md_b[p];
                mv_b[p]   = 1'b0;
            end
        end
        if (acc_b) begin
            mv_b[0] = 1'b1;
            md_b[0] = din;
        end
        // Lock-step: everything, bubbles included, moves one slot when the consumer is ready.
        if (rdy) begin
            for (int p = 3; p > 0; p--) begin
                mv_l[p] = mv_l[p-1];
                if (mv_l[p-1]) md_l[p] = md_l[p-1];
            end
            mv_l[0] = vin;
            if (vin) md_l[0] = din;
        end
    endtask

    task automatic cyc();
        #1;
        check_all();
        model_update();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_data", 32'(b_data), 32'(0));
        rst_n = 1'b1;
        #1 chk("rst_ready", 32'(b_ready), 32'(1));
        cyc();

        // Streaming 1..8 with the consumer always ready.
        rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin
                chk("stream_first_valid", 32'(b_valid), 32'(1));
                chk("stream_first_data",  32'(b_data),  32'(1));
                chk("stream_count",       32'(b_cnt),   32'(4));
            end
            vin = 1'b1;
            din = 8'(k);
            cyc();
        end
        vin = 1'b0;
        repeat (6) cyc();

        // Bubble collapse under backpressure.
        rdy = 1'b0;
        vin = 1'b1; din = 8'h0A; cyc();
        vin = 1'b0; cyc(); cyc();
        vin = 1'b1; din = 8'h0B; cyc();
        vin = 1'b0; repeat (3) cyc();
        chk("bub_count", 32'(b_cnt),   32'(2));
        chk("bub_valid", 32'(b_valid), 32'(1));
        chk("bub_out",   32'(b_data),  32'(8'h0A));
        #1;
        chk("bub_ready",      32'(b_ready), 32'(1));
        chk("ls_ready_stall", 32'(l_ready), 32'(0));
        rdy = 1'b1;
        cyc();
        chk("bub_next_valid", 32'(b_valid), 32'(1));
        chk("bub_next_data",  32'(b_data),  32'(8'h0B));
        repeat (4) cyc();

        // Lock-step keeps the two-cycle gap between beats.
        vin = 1'b1; din = 8'h0A; cyc();
        vin = 1'b0; cyc(); cyc();
        vin = 1'b1; din = 8'h0B; cyc();
        vin = 1'b0;
        chk("gap_a", 32'(l_data), 32'(8'h0A));
        cyc();
        chk("gap_hole1", 32'(l_valid), 32'(0));
        cyc();
        chk("gap_hole2", 32'(l_valid), 32'(0));
        cyc();
        chk("gap_b", 32'(l_data), 32'(8'h0B));
        repeat (3) cyc();

        // Fill the collapsing chain, then wiggle the input: payload must not move.
        rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vin = 1'b1;
            din = 8'(8'h11 + k);
            cyc();
        end
        vin = 1'b0;
        #1;
        chk("full_ready", 32'(b_ready), 32'(0));
        chk("full_count", 32'(b_cnt),   32'(4));
        chk("full_out",   32'(b_data),  32'(8'h11));
        for (int k = 0; k < 4; k++) begin
            vin = (k % 2 == 0);
            din = 8'hFF;
            cyc();
            chk("gate_data", 32'(b_data), 32'(8'h11));
        end

        // Flush a full chain while a new beat is offered.
        flush = 1'b1; vin = 1'b1; din = 8'h55;
        #1 chk("flush_ready", 32'(b_ready), 32'(0));
        cyc();
        flush = 1'b0; vin = 1'b0;
        chk("flush_count", 32'(b_cnt),   32'(0));
        chk("flush_valid", 32'(b_valid), 32'(0));
        rdy = 1'b1;
        repeat (6) cyc();

        // Random traffic with backpressure and occasional flushes.
        repeat (600) begin
            vin   = 1'($urandom_range(0, 1));
            din   = 8'($urandom);
            rdy   = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            cyc();
        end

        // Asynchronous reset in the middle of a stream.
        flush = 1'b0; rdy = 1'b1; vin = 1'b1; din = 8'h77;
        cyc(); cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(b_valid), 32'(0));
        chk("mid_rst_data",  32'(b_data),  32'(0));
        chk("mid_rst_count", 32'(b_cnt),   32'(0));
        chk("mid_rst_ls",    32'(l_cnt),   32'(0));
        model_reset();
        @(negedge clk);
        vin = 1'b0;
        rst_n = 1'b1;
        repeat (3) cyc();
        vin = 1'b1; din = 8'h3C;
        cyc();
        vin = 1'b0;
        repeat (5) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
